// File: rtl/vertex_pkg.sv
// Shared types for the vertex accumulator: FIFO entry and FSM state.
// FV_size / Max_Node_id normally come from the project define header; defaults apply otherwise.
`ifndef FV_size
`define FV_size 16
`endif
`ifndef Max_Node_id
`define Max_Node_id 16
`endif

package vertex_pkg;

  localparam int FV_W = `FV_size;
  localparam int ID_W = $clog2(`Max_Node_id);

  typedef struct packed {
    logic [ID_W-1:0] node_id;
    logic [FV_W-1:0] data;
  } vtx_result_t;

  typedef enum logic {
    S_IDLE,
    S_ACC
  } acc_state_t;

endpackage

// File: rtl/vertex_accumulator_if.sv
// Bus bundles around the accumulator: partial-sum input from the PE and the
// result output to writeback.
interface vertex_pe_if;
  import vertex_pkg::*;

  logic            PE_valid;
  logic [FV_W-1:0] PE_data;
  logic [ID_W-1:0] PE_node_id;
  logic            PE_last;
  logic            Acc_stall;

  modport master (output PE_valid, PE_data, PE_node_id, PE_last, input Acc_stall);
  modport slave  (input PE_valid, PE_data, PE_node_id, PE_last, output Acc_stall);
endinterface

interface vertex_out_if;
  import vertex_pkg::*;

  logic            Out_valid;
  logic [FV_W-1:0] Out_data;
  logic [ID_W-1:0] Out_node_id;
  logic            Out_ready;

  modport master (output Out_valid, Out_data, Out_node_id, input Out_ready);
  modport slave  (input Out_valid, Out_data, Out_node_id, output Out_ready);
endinterface

// File: rtl/vertex_out_fifo.sv
// Result FIFO with a registered head entry; push into an empty FIFO shows up
// at the head one cycle later (no bypass).
module vertex_out_fifo
  import vertex_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  vtx_result_t                push_entry,
  input  logic                       pop,
  output vtx_result_t                head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  vtx_result_t   mem [DEPTH];
  vtx_result_t   head_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] remain;
  logic [PW-1:0] next_rd;

  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign remain  = count_q - CW'(do_pop);
  assign next_rd = rd_ptr_q + PW'(do_pop);

  // NOTE: the storage array carries no reset; count_q alone says which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= next_rd;
      count_q  <= remain + CW'(do_push);
      // Head follows the oldest surviving entry; an empty FIFO takes the new push.
      if (remain != '0)  head_q <= mem[next_rd];
      else if (do_push)  head_q <= push_entry;
    end
  end

  assign head  = head_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/vertex_accumulator.sv
// Sums per-chunk dot-product partials per node and queues finished results.
// Build option: define ACC_SAT_EN for a saturating adder (default wraps).
module vertex_accumulator
  import vertex_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  vertex_pe_if.slave   pe,
  vertex_out_if.master out,
  output logic         Id_err
);

  localparam int CW = $clog2(DEPTH+1);

  acc_state_t      state_q, state_d;
  logic [FV_W-1:0] acc_sum_q, acc_sum_d;
  logic [ID_W-1:0] acc_id_q, acc_id_d;
  logic            id_err_q, id_err_d;

  logic            accept;
  logic            continuing;
  logic [FV_W-1:0] beat_sum;
  logic            push;
  vtx_result_t     push_entry;

  vtx_result_t     fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  function automatic logic [FV_W-1:0] acc_add(input logic [FV_W-1:0] a,
                                             input logic [FV_W-1:0] b);
`ifdef ACC_SAT_EN
    logic [FV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[FV_W] ? '1 : s[FV_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign accept     = pe.PE_valid && !fifo_full;
  // A beat for a different node restarts accumulation as if it were a first beat.
  assign continuing = (state_q == S_ACC) && (pe.PE_node_id == acc_id_q);
  assign beat_sum   = continuing ? acc_add(acc_sum_q, pe.PE_data) : pe.PE_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_sum_q <= '0;
      acc_id_q  <= '0;
      id_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_sum_q <= acc_sum_d;
      acc_id_q  <= acc_id_d;
      id_err_q  <= id_err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    acc_sum_d  = acc_sum_q;
    acc_id_d   = acc_id_q;
    id_err_d   = id_err_q;
    push       = 1'b0;
    push_entry = '0;
    if (accept) begin
      if ((state_q == S_ACC) && !continuing) id_err_d = 1'b1;
      if (pe.PE_last) begin
        push               = 1'b1;
        push_entry.node_id = pe.PE_node_id;
        push_entry.data    = beat_sum;
        state_d            = S_IDLE;
      end else begin
        acc_sum_d = beat_sum;
        acc_id_d  = pe.PE_node_id;
        state_d   = S_ACC;
      end
    end
  end

  vertex_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (out.Out_ready),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Stall depends only on registered occupancy, never on Out_ready.
  assign pe.Acc_stall    = (fifo_count == CW'(DEPTH));
  assign out.Out_valid   = !fifo_empty;
  assign out.Out_data    = fifo_head.data;
  assign out.Out_node_id = fifo_head.node_id;
  assign Id_err          = id_err_q;

endmodule

// File: doc/vertex_accumulator.md
# vertex_accumulator

- Downstream stage of the vertex processing element.
- Sums the per-cycle 4-lane dot-product partials for one node across the successive 4-element chunks of its feature vector.
- Queues each completed node result in a small output FIFO, presented to writeback under a valid/ready handshake.
- Applies backpressure to the upstream issue controller when that FIFO is full.

## Interface
- DEPTH, 4: output FIFO entries (power of two, ≥2).
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- PE_valid  in  1  partial-sum beat present this cycle.
- PE_data  in  `FV_size  partial sum from the vertex PE (unsigned).
- PE_node_id  in  $clog2(`Max_Node_id)  node id of the beat.
- PE_last  in  1  final chunk of this node.
- Acc_stall  out  1  FIFO full; upstream must hold its beat.
- Out_valid  out  1  FIFO head valid.
- Out_data  out  `FV_size  accumulated vertex feature.
- Out_node_id  out  $clog2(`Max_Node_id)  node id of the result.
- Out_ready  in  1  writeback accepts the head.
- Id_err  out  1  sticky node-id mismatch flag.

## Operation
- A beat is accepted when PE_valid && !Acc_stall.
  - Beats presented while stalled are ignored; upstream re-presents them.
- FSM states:
  - IDLE: no partial sum held.
  - ACC: acc_sum and acc_id hold an open node.
- IDLE, accepted beat:
  - with PE_last: push {PE_node_id, PE_data}; stay IDLE.
  - without PE_last: acc_sum←PE_data, acc_id←PE_node_id; go to ACC.
- ACC, accepted beat with PE_node_id == acc_id:
  - sum = acc_sum + PE_data.
  - with PE_last: push {acc_id, sum}; go to IDLE.
  - without PE_last: acc_sum←sum.
- ACC, accepted beat with PE_node_id ≠ acc_id:
  - set Id_err; discard acc_sum.
  - Treat the beat as a first beat using the IDLE rules.
- Addition wraps modulo 2^`FV_size`, matching the truncating arithmetic of the PE.
- FIFO:
  - pop when Out_valid && Out_ready.
  - push and pop in the same cycle: count unchanged, order preserved.
- Acc_stall = (count == DEPTH).
  - Registered-state only; no combinational path from Out_ready.
  - A pop in a full cycle does not permit a same-cycle push.
- Id_err is cleared only by reset.

## Timing
- Reset values:
  - Acc_stall=0, Out_valid=0, Out_data=0, Out_node_id=0, Id_err=0.
  - FSM=IDLE, acc_sum=0, FIFO count=0.
- Reset mid-operation drops the open partial sum and all queued results.
- Latency: accepted PE_last beat at cycle N → Out_valid=1 at N+1, including when the FIFO was empty (no bypass).
- Out_data and Out_node_id are FIFO head registers. They are stable while Out_valid && !Out_ready.
- Acc_stall rises the cycle after the DEPTH-th push without a pop. It falls the cycle after the first pop.
- Throughput: one beat per cycle while not stalled. Idle cycles (PE_valid=0) inside a node are allowed and leave the state unchanged.

## Configuration
- ACC_SAT_EN defined:
  - Unsigned saturating add: the sum clamps to 2^`FV_size`−1 on carry-out.
  - Once clamped, the sum stays clamped until the node's push.
- ACC_SAT_EN undefined: wrap-around add as above.
- All other behaviour is identical in both builds.

## Structure
- `FV_size` and `Max_Node_id` come from the project-wide define header.
- Package vertex_pkg holds:
  - typedef vtx_result_t {node_id, data}, the FIFO entry;
  - the FSM state enum acc_state_t.
- Sub-module vertex_out_fifo:
  - parameterised DEPTH;
  - registered head;
  - full/empty/count outputs.
- The FSM and adder stay in vertex_accumulator.

## Test plan
- Beats 10,20,30,40 (id 5, last on 40), Out_ready=1 → one result {5,100}, Out_valid exactly one cycle after the last beat.
- Single beat 7 (id 3, last) → {3,7}; FSM never enters ACC.
- Out_ready=0, 5 single-beat nodes with DEPTH=4 → Acc_stall=1 after 4th push; 5th held. Raise Out_ready → 4 results in order, then 5th accepted and emitted.
- Id 2 beat 0x0010 (not last), then id 9 beat 0x0003 (last) → Id_err=1 sticky; result {9,3}.
- Beats 0xFFF0 + 0x0020 (FV_size=16, last):
  - ACC_SAT_EN undefined → 0x0010.
  - ACC_SAT_EN defined → 0xFFFF.
- Reset asserted mid-node with 2 results queued → next cycle all outputs 0. Subsequent node {1,4} produces only {1,4}.
